// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and registered select sequencer for the shared 16-to-1 mux.
// Define MUXARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles of contended ownership.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:15]      req,
  output logic [0:3]       sel,
  output logic [0:15]      grant,
  output logic             valid,
  output logic [CNT_W-1:0] hold_cnt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_param_check
    $error("mux16_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [0:15]      grant_q, grant_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [0:15]      cand;
  logic [3:0]       idx;
  logic [3:0]       win;
  logic             found;
  logic [CNT_W-1:0] hold_inc;

  function automatic logic [0:15] onehot(input logic [3:0] i);
    logic [0:15] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Masking with the current grant excludes the owner on release/rotation; grant is 0 in idle.
  always_comb begin
    cand  = req & ~grant_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < 16; k++) begin
      idx = ptr_q + 4'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hold_inc = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StGrant;
          sel_d      = win;
          grant_d    = onehot(win);
          ptr_d      = win + 4'd1;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!req[sel_q]) begin
          if (found) begin
            sel_d      = win;
            grant_d    = onehot(win);
            ptr_d      = win + 4'd1;
            hold_cnt_d = '0;
          end else begin
            state_d    = StIdle;
            grant_d    = '0;
            hold_cnt_d = '0;
          end
        end else begin
`ifdef MUXARB_HOLD_LIMIT_EN
          if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            hold_cnt_d = '0;
            if (found) begin
              sel_d   = win;
              grant_d = onehot(win);
              ptr_d   = win + 4'd1;
            end
          end else begin
            hold_cnt_d = hold_inc;
          end
`else
          hold_cnt_d = hold_inc;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      grant_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign sel      = sel_q;
  assign grant    = grant_q;
  assign valid    = |grant_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter (MAX_HOLD=4, CNT_W=3).
module tb_mux16_rr_arbiter;

  localparam int unsigned MaxHold = 4;
  localparam int unsigned CntW    = 3;

  logic            clk;
  logic            rst_n;
  logic [0:15]     req;
  logic [0:3]      sel;
  logic [0:15]     grant;
  logic            valid;
  logic [CntW-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  mux16_rr_arbiter #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (CntW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i occupies the MSB-first position i of a [0:15] vector.
  function automatic logic [31:0] gvec(input int i);
    return 32'(16'h8000 >> i);
  endfunction

  task automatic check_owner(input string tag, input int i, input int h);
    check_eq({tag, " sel"}, 32'(sel), 32'(i));
    check_eq({tag, " grant"}, 32'(grant), gvec(i));
    check_eq({tag, " valid"}, 32'(valid), 32'd1);
    check_eq({tag, " hold"}, 32'(hold_cnt), 32'(h));
  endtask

  task automatic check_idle(input string tag, input int s);
    check_eq({tag, " sel"}, 32'(sel), 32'(s));
    check_eq({tag, " grant"}, 32'(grant), 32'd0);
    check_eq({tag, " valid"}, 32'(valid), 32'd0);
    check_eq({tag, " hold"}, 32'(hold_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int order[4] = '{2, 9, 14, 2};

  initial begin
    rst_n = 1'b0;
    req   = '0;

    // Reset then idle
    tick();
    check_idle("rst1", 0);
    tick();
    check_idle("rst2", 0);
    rst_n = 1'b1;
    tick();
    check_idle("idle", 0);

    // Single request, then release
    req[5] = 1'b1;
    tick();
    check_owner("single", 5, 0);
    req[5] = 1'b0;
    tick();
    check_idle("release", 5);

    // Round-robin fairness with back-to-back switches
    do_reset();
    req = '0;
    req[2] = 1'b1; req[9] = 1'b1; req[14] = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) begin
      check_owner($sformatf("rr%0d c0", r), order[r], 0);
      tick();
      check_owner($sformatf("rr%0d c1", r), order[r], 1);
      tick();
      check_owner($sformatf("rr%0d c2", r), order[r], 2);
      if (r < 3) begin
        req[order[r]] = 1'b0;
        tick();
        req[order[r]] = 1'b1;
      end
    end

    // Wrap-around from ptr=15
    do_reset();
    req = '0;
    req[14] = 1'b1;
    tick();
    check_owner("wrap14", 14, 0);
    req = '0;
    req[0] = 1'b1; req[15] = 1'b1;
    tick();
    check_owner("wrap15", 15, 0);
    req[15] = 1'b0;
    tick();
    check_owner("wrap0", 0, 0);
    req = '0;
    tick();
    check_idle("wrapidle", 0);

    // Contended hold: forced rotation only with the hold limit enabled
    do_reset();
    req = '0;
    req[3] = 1'b1; req[7] = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
`ifdef MUXARB_HOLD_LIMIT_EN
      check_owner($sformatf("hold%0d", k), ((k / 4) % 2 == 1) ? 7 : 3, k % 4);
`else
      check_owner($sformatf("hold%0d", k), 3, (k > 7) ? 7 : k);
`endif
      tick();
    end

    // Reset mid-grant clears pointer; 1 beats 7 afterwards
    do_reset();
    req = '0;
    req[7] = 1'b1;
    tick();
    tick();
    tick();
    check_owner("mid pre", 7, 2);
    rst_n = 1'b0;
    tick();
    check_idle("mid rst", 0);
    rst_n = 1'b1;
    req[1] = 1'b1;
    tick();
    check_owner("mid ptr", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
Round-robin arbiter and select sequencer for the shared 16-to-1 bit mux. Sixteen requesters contend for the mux. The block grants one requester at a time, drives the registered 4-bit mux select and a one-hot grant, and holds the grant until the requester releases. An optional hold limit forces rotation. It sits directly in front of the mux16to1 select input.

Parameters:
MAX_HOLD, 8, max consecutive cycles a grant may be held while others wait (only used with MUXARB_HOLD_LIMIT_EN); legal range 2..255
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low, sampled on rising clk
req  input  [0:15]  request lines; req[i] high = requester i wants the mux; index order matches the mux in[0:15]
sel  output  [0:3]  mux select, registered; sel = i routes in[i]; sel[0] is MSB
grant  output  [0:15]  one-hot grant, registered; grant[i] high while requester i owns the mux
valid  output  1  high when a grant is active; sel is meaningful only when valid=1
hold_cnt  output  [CNT_W-1:0]  cycles the current grant has been held, 0 on the first grant cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): sel=0, grant=0, valid=0, hold_cnt=0, rotation pointer ptr=0, state IDLE. Reset mid-grant drops the grant on that edge with no release handshake.
- ptr (4 bits) is the search start. Winner = first i with req[i]=1, scanning ptr, ptr+1, … with wrap mod 16.
- States:
  - IDLE: valid=0, grant=0. If any req=1, load winner into sel/grant, set valid=1, hold_cnt=0, ptr=winner+1 (15 wraps to 0), go to GRANT. Latency: req sampled at edge N, grant visible after edge N+1 registers (1-cycle latency). Else stay.
  - GRANT, owner w:
    - If req[w]=0 (release): re-arbitrate the same cycle over req with bit w masked. If there is a winner, switch sel/grant at the next edge with no dead cycle, hold_cnt=0, ptr=winner+1. If there is none, go to IDLE with valid=0, grant=0; sel keeps its last value.
    - If req[w]=1: hold, and hold_cnt increments, saturating at 2^CNT_W-1.
- Simultaneous requests: resolved purely by ptr order. The just-served requester has the lowest priority next round.
- Grant is always one-hot or zero; valid = |grant. sel never changes while valid=1 and the owner is still requesting, except on a forced rotation.
- Requests arriving mid-grant wait; there is no preemption except a forced rotation.
- All outputs are registered; no combinational path from req to sel/grant.

Optional Feature:
MUXARB_HOLD_LIMIT_EN
- Defined: in GRANT, if req[w]=1 and hold_cnt = MAX_HOLD-1, re-arbitrate with w masked.
  - If another requester wins, switch to it at the next edge: hold_cnt=0, ptr=winner+1. The displaced owner keeps req high and re-enters rotation normally.
  - If no other requester exists, keep w and reset hold_cnt to 0.
  - Worst-case wait for any requester: 15*MAX_HOLD cycles.
- Not defined: no forced rotation. The grant persists until the owner releases. hold_cnt still counts and saturates.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 -> sel=0, grant=0, valid=0, hold_cnt=0 every cycle.
- Single request: req[5]=1 at edge N -> after edge N+1: valid=1, sel=5, grant[5]=1; drop req[5] -> next edge valid=0, grant=0.
- Round-robin fairness: req[2]=req[9]=req[14]=1, each owner releases after 3 cycles, then re-asserts -> grant order 2, 9, 14, 2, … with back-to-back switches and no idle cycle between them.
- Wrap-around: ptr=15 (after serving 14), req[0]=req[15]=1 -> grant 15, then 0.
- Hold limit (macro defined, MAX_HOLD=4): req[3] and req[7] held high -> grant 3 for 4 cycles (hold_cnt 0..3), then 7 for 4, then 3 again. Same stimulus without the macro -> grant stays at 3 indefinitely and hold_cnt climbs and saturates.
- Reset mid-grant: grant[7] active, hold_cnt=2, rst_n=0 one cycle -> next edge all outputs 0, ptr=0. With req[7] and req[1] high after release -> grant 1 first.
